// File: rtl/lsu_ctrl.sv
// Load/store initiator: sequences byte/half/word accesses to a word-addressed
// memory with sub-word extraction on loads and read-modify-write on sub-word stores.
module lsu_ctrl #(
  parameter int MEM_WORDS   = 32,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read_flag,
  output logic        mem_write_flag,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_val,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q;
  logic        store_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        rd_flag_q;
  logic        wr_flag_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_val_q;

  logic        req_err_d;
  logic [7:0]  ld_byte_d;
  logic [15:0] ld_half_d;
  logic [31:0] load_data_d;
  logic [31:0] merge_data_d;

  always_comb begin
    req_err_d = 1'b0;
    case (req_size)
      2'b01:   req_err_d = req_addr[0];
      2'b10:   req_err_d = |req_addr[1:0];
      2'b11:   req_err_d = 1'b1;
      default: req_err_d = 1'b0;
    endcase
    if (CHECK_RANGE && (req_addr >= MEM_BYTES)) begin
      req_err_d = 1'b1;
    end
  end

  // Lane selection works on the live memory word; only the latched request is used.
  always_comb begin
    ld_byte_d = mem_rdata[{lane_q, 3'b000} +: 8];
    ld_half_d = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_data_d = {{24{signed_q & ld_byte_d[7]}}, ld_byte_d};
      2'b01:   load_data_d = {{16{signed_q & ld_half_d[15]}}, ld_half_d};
      default: load_data_d = mem_rdata;
    endcase
    merge_data_d = mem_rdata;
    if (size_q == 2'b00) begin
      merge_data_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      merge_data_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      rd_flag_q    <= 1'b0;
      wr_flag_q    <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_val_q    <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            store_q      <= req_store;
            signed_q     <= req_signed;
            size_q       <= req_size;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata[15:0];
            resp_rdata_q <= 32'h0;
            if (req_err_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
              resp_err_q <= 1'b0;
              if (req_store && (req_size == 2'b10)) begin
                state_q   <= WR;
                wr_flag_q <= 1'b1;
                mem_val_q <= req_wdata;
              end else begin
                state_q   <= RD;
                rd_flag_q <= 1'b1;
              end
            end
          end
        end
        RD: begin
          rd_flag_q <= 1'b0;
          if (store_q) begin
            state_q   <= WR;
            wr_flag_q <= 1'b1;
            mem_val_q <= merge_data_d;
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data_d;
          end
        end
        WR: begin
          wr_flag_q    <= 1'b0;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'h0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = resp_rdata_q;
  assign mem_read_flag  = rd_flag_q;
  assign mem_write_flag = wr_flag_q;
  assign mem_addr       = mem_addr_q;
  assign mem_val        = mem_val_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random traffic against a
// byte-level reference memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_val;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.MEM_WORDS(32), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_addr(mem_addr), .mem_val(mem_val), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory (what the DUT talks to) and the reference model's view.
  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  logic        mem_sync = 1'b0;

  assign mem_rdata = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_sync) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else if (mem_write_flag) begin
      mem[mem_addr[6:2]] <= mem_val;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: expected result, latency and flag activity of one access.
  function automatic void ref_access(input bit st, input logic [1:0] sz, input bit sg,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er,
                                     output int lat, output int nrd, output int nwr);
    int w, sh;
    logic [31:0] word, mask, part;
    er  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 128);
    rd  = 32'h0;
    nrd = 0;
    nwr = 0;
    lat = 1;
    if (er) return;
    w    = int'(a / 4);
    word = ref_mem[w];
    if (sz == 2'd0) begin
      sh = int'(a % 4) * 8; mask = 32'hFF;
    end else if (sz == 2'd1) begin
      sh = int'((a % 4) / 2) * 16; mask = 32'hFFFF;
    end else begin
      sh = 0; mask = 32'hFFFF_FFFF;
    end
    if (st) begin
      ref_mem[w] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      nwr = 1;
      nrd = (sz == 2'd2) ? 0 : 1;
      lat = (sz == 2'd2) ? 2 : 3;
    end else begin
      part = (word >> sh) & mask;
      if (sg && sz == 2'd0 && part >= 128)   part = part + 32'hFFFF_FF00;
      if (sg && sz == 2'd1 && part >= 32768) part = part + 32'hFFFF_0000;
      rd  = part;
      nrd = 1;
      lat = 2;
    end
  endfunction

  // Issues one request and observes the DUT until resp_valid (bounded).
  task automatic do_req(input bit st, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nrd, output int nwr, output int nboth,
                        output logic [31:0] wval, output logic [31:0] maddr);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    // Scramble inputs to confirm the request was latched.
    req_valid = 1'b0; req_store = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    rd = 32'hx; er = 1'bx; lat = 0; nrd = 0; nwr = 0; nboth = 0;
    wval = 32'hx; maddr = 32'hx;
    for (int c = 1; c <= 10; c++) begin
      if (mem_read_flag)  begin nrd++; maddr = mem_addr; end
      if (mem_write_flag) begin nwr++; wval = mem_val; maddr = mem_addr; end
      if (mem_read_flag && mem_write_flag) nboth++;
      if (resp_valid) begin
        lat = c; rd = resp_rdata; er = resp_err;
        break;
      end
      @(negedge clk);
    end
    $display("txn st=%0d sz=%0d sg=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d rd=%0d wr=%0d",
             st, sz, sg, a, wd, rd, er, lat, nrd, nwr);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_sync = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else n_pass++;
    n_checks++; if ({resp_valid, resp_err, mem_read_flag, mem_write_flag} !== 4'b0)
      $display("FAIL reset_flags got %b exp 0000", {resp_valid, resp_err, mem_read_flag, mem_write_flag}); else n_pass++;
    n_checks++; if ({resp_rdata, mem_addr, mem_val} !== 96'h0)
      $display("FAIL reset_buses got %h exp 0", {resp_rdata, mem_addr, mem_val}); else n_pass++;
    mem_sync = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0)
      $display("FAIL post_reset_idle got ready=%b valid=%b exp 1 0", req_ready, resp_valid); else n_pass++;
  endtask

  task automatic test_load_word();
    logic [31:0] rd, wv, ma, e_rd; logic er, e_er; int lat, nrd, nwr, nb, e_lat, e_nrd, e_nwr;
    ref_access(0, 2'd2, 0, 32'h0, 32'h0, e_rd, e_er, e_lat, e_nrd, e_nwr);
    do_req(0, 2'd2, 0, 32'h0, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== 32'h0000_000F || er !== 1'b0) $display("FAIL load_word got %h/%b exp 0000000f/0", rd, er); else n_pass++;
    n_checks++; if (lat !== 2 || nrd !== 1 || nwr !== 0)
      $display("FAIL load_word_timing got lat=%0d rd=%0d wr=%0d exp 2 1 0", lat, nrd, nwr); else n_pass++;
  endtask

  task automatic test_byte_store_load();
    logic [31:0] rd, wv, ma, e_rd; logic er, e_er; int lat, nrd, nwr, nb, e_lat, e_nrd, e_nwr;
    ref_access(1, 2'd0, 0, 32'h5, 32'h80, e_rd, e_er, e_lat, e_nrd, e_nwr);
    do_req(1, 2'd0, 0, 32'h5, 32'h80, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (wv !== 32'h0000_8000 || lat !== 3 || nrd !== 1 || nwr !== 1)
      $display("FAIL byte_store got val=%h lat=%0d rd=%0d wr=%0d exp 00008000 3 1 1", wv, lat, nrd, nwr); else n_pass++;
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) $display("FAIL byte_store_resp got %h/%b exp 0/0", rd, er); else n_pass++;
    n_checks++; if (mem[1] !== 32'h0000_8000) $display("FAIL byte_store_mem got %h exp 00008000", mem[1]); else n_pass++;
    do_req(0, 2'd0, 1, 32'h5, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== 32'hFFFF_FF80) $display("FAIL load_byte_signed got %h exp ffffff80", rd); else n_pass++;
    do_req(0, 2'd0, 0, 32'h5, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== 32'h0000_0080) $display("FAIL load_byte_unsigned got %h exp 00000080", rd); else n_pass++;
  endtask

  task automatic test_half_rmw();
    logic [31:0] rd, wv, ma, e_rd; logic er, e_er; int lat, nrd, nwr, nb, e_lat, e_nrd, e_nwr;
    ref_access(1, 2'd1, 0, 32'h2, 32'hBEEF, e_rd, e_er, e_lat, e_nrd, e_nwr);
    do_req(1, 2'd1, 0, 32'h2, 32'hBEEF, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (wv !== 32'hBEEF_000F || nrd !== 1 || nwr !== 1)
      $display("FAIL half_rmw got val=%h rd=%0d wr=%0d exp beef000f 1 1", wv, nrd, nwr); else n_pass++;
    do_req(0, 2'd2, 0, 32'h0, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== 32'hBEEF_000F) $display("FAIL half_rmw_readback got %h exp beef000f", rd); else n_pass++;
  endtask

  task automatic test_errors();
    logic [31:0] rd, wv, ma; logic er; int lat, nrd, nwr, nb;
    logic [31:0] addrs [4] = '{32'h6, 32'h3, 32'h0, 32'h80};
    logic [1:0]  sizes [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
    for (int i = 0; i < 4; i++) begin
      do_req(0, sizes[i], 0, addrs[i], 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
      n_checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || nrd !== 0 || nwr !== 0)
        $display("FAIL error_case%0d got err=%b rdata=%h lat=%0d rd=%0d wr=%0d exp 1 0 1 0 0",
                 i, er, rd, lat, nrd, nwr); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, wv, ma; logic er; int lat, nrd, nwr, nb, guard;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_addr = 32'h11; req_wdata = 32'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!mem_write_flag && guard < 6) begin
      @(negedge clk);
      guard++;
    end
    n_checks++; if (mem_write_flag !== 1'b1) $display("FAIL rst_mid_reach_wr got %b exp 1", mem_write_flag); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if ({req_ready, resp_valid, resp_err, mem_read_flag, mem_write_flag} !== 5'b10000 ||
                    {resp_rdata, mem_addr, mem_val} !== 96'h0)
      $display("FAIL rst_mid_outputs got ready=%b v=%b e=%b r=%b w=%b buses=%h exp 1 0 0 0 0 0",
               req_ready, resp_valid, resp_err, mem_read_flag, mem_write_flag, {resp_rdata, mem_addr, mem_val}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_req(0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== ref_mem[4]) $display("FAIL rst_mid_word_unchanged got %h exp %h", rd, ref_mem[4]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wv, ma, e_rd; logic er, e_er; int lat, nrd, nwr, nb, e_lat, e_nrd, e_nwr;
    logic rdy [1:5]; logic vld [1:5];
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_addr = 32'h08; req_wdata = 32'h1111_1111;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      rdy[k] = req_ready; vld[k] = resp_valid;
      if (k == 1) begin req_addr = 32'h0C; req_wdata = 32'h2222_2222; end
      if (k == 4) req_valid = 1'b0;
    end
    $display("txn back_to_back ready=%b%b%b%b%b resp=%b%b%b%b%b", rdy[1], rdy[2], rdy[3], rdy[4], rdy[5],
             vld[1], vld[2], vld[3], vld[4], vld[5]);
    n_checks++; if (rdy[1] !== 1'b0 || rdy[2] !== 1'b0 || vld[2] !== 1'b1)
      $display("FAIL b2b_first got ready1=%b ready2=%b resp2=%b exp 0 0 1", rdy[1], rdy[2], vld[2]); else n_pass++;
    n_checks++; if (rdy[3] !== 1'b1 || rdy[4] !== 1'b0 || vld[5] !== 1'b1)
      $display("FAIL b2b_second got ready3=%b ready4=%b resp5=%b exp 1 0 1", rdy[3], rdy[4], vld[5]); else n_pass++;
    ref_access(1, 2'd2, 0, 32'h08, 32'h1111_1111, e_rd, e_er, e_lat, e_nrd, e_nwr);
    ref_access(1, 2'd2, 0, 32'h0C, 32'h2222_2222, e_rd, e_er, e_lat, e_nrd, e_nwr);
    do_req(0, 2'd2, 0, 32'h08, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== 32'h1111_1111) $display("FAIL b2b_readback0 got %h exp 11111111", rd); else n_pass++;
    do_req(0, 2'd2, 0, 32'h0C, 32'h0, rd, er, lat, nrd, nwr, nb, wv, ma);
    n_checks++; if (rd !== 32'h2222_2222) $display("FAIL b2b_readback1 got %h exp 22222222", rd); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, wv, ma, e_rd, a, wd; logic er, e_er; bit st, sg; logic [1:0] sz;
    int lat, nrd, nwr, nb, e_lat, e_nrd, e_nwr;
    for (int i = 0; i < 60; i++) begin
      st = 1'($urandom); sg = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(128, 200)) : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      ref_access(st, sz, sg, a, wd, e_rd, e_er, e_lat, e_nrd, e_nwr);
      do_req(st, sz, sg, a, wd, rd, er, lat, nrd, nwr, nb, wv, ma);
      n_checks++; if (rd !== e_rd || er !== e_er)
        $display("FAIL rand%0d_resp got %h/%b exp %h/%b", i, rd, er, e_rd, e_er); else n_pass++;
      n_checks++; if (lat !== e_lat || nrd !== e_nrd || nwr !== e_nwr || nb !== 0)
        $display("FAIL rand%0d_timing got lat=%0d rd=%0d wr=%0d both=%0d exp %0d %0d %0d 0",
                 i, lat, nrd, nwr, nb, e_lat, e_nrd, e_nwr); else n_pass++;
      if (!e_er) begin
        n_checks++; if (ma !== {a[31:2], 2'b00}) $display("FAIL rand%0d_addr got %h exp %h", i, ma, {a[31:2], 2'b00}); else n_pass++;
        if (st) begin
          n_checks++; if (wv !== ref_mem[a[6:2]]) $display("FAIL rand%0d_wval got %h exp %h", i, wv, ref_mem[a[6:2]]); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_C300;
    ref_mem[0] = 32'h0000_000F;
    ref_mem[1] = 32'h0000_0000;
    test_reset();
    test_load_word();
    test_byte_store_load();
    test_half_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the core datapath and the word-addressed data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Drives the memory's read flag, write flag, address and write-value inputs. Memory read data is asynchronous, returned on the same cycle.
- Performs sub-word extraction with sign/zero extension on loads, and read-modify-write merging on sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in data memory. Valid byte addresses are 0 to MEM_WORDS*4-1.
- CHECK_RANGE, 1, when 1, addresses >= MEM_WORDS*4 are rejected with resp_err. When 0, no range check is made and the memory aliases them.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or out-of-range
- mem_read_flag  out  1  to memory read flag
- mem_write_flag  out  1  to memory write flag
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_val  out  32  write value to memory
- mem_rdata  in  32  asynchronous memory read data

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset (async): state IDLE. All outputs 0 (resp_valid, resp_rdata, resp_err, mem_read_flag, mem_write_flag, mem_addr, mem_val) except req_ready=1. Request latches are cleared.
- req_ready=1 only in IDLE. Accept = req_valid && req_ready at a rising edge. All request fields are latched at accept, so inputs are don't-care afterwards.
- Error check at accept:
  - size 11 is illegal.
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - With CHECK_RANGE=1, addr>=MEM_WORDS*4 is out of range.
  - Any error goes IDLE->RESP with resp_err=1 and resp_rdata=0. No mem flag is asserted at any time.
- Load: IDLE->RD->RESP->IDLE.
  - In RD: mem_read_flag=1, mem_addr valid.
  - At the RD->RESP edge, resp_rdata is registered from mem_rdata:
    - byte: lane addr[1:0], bits [8*k+7:8*k]
    - half: lane addr[1], bits [16*h+15:16*h]
    - extended per req_signed
  - resp_valid is high for exactly the RESP cycle.
- Store word: IDLE->WR->RESP. In WR, mem_write_flag=1 and mem_val=wdata. The write commits at the WR->RESP edge.
- Store byte/half: IDLE->RD->WR->RESP.
  - In RD, mem_read_flag=1 and the old word is captured into a merge register.
  - In WR, mem_val = old word with the addressed lane replaced by wdata[7:0] or wdata[15:0]; mem_write_flag=1.
- Flag rules:
  - mem_read_flag and mem_write_flag are never high in the same cycle.
  - Both flags are 0 in IDLE and RESP.
  - mem_addr holds its value outside access states.
- Latency: accept edge N gives resp_valid in the cycle after these edges:
  - load: edge N+1
  - store word: edge N+1
  - sub-word store: edge N+2
  - error: edge N
- Back-to-back: RESP->IDLE is unconditional, so a new request is accepted at the edge ending the first IDLE cycle after RESP. No request is accepted during RESP.
- Reset mid-operation aborts immediately. No write is issued afterwards, and a pending RMW write is dropped.
- Stores return resp_rdata=0 and resp_err=0.

Test Plan:
1. After reset (memory word0=0x0000000F), load word addr 0x00 -> RD one cycle with mem_read_flag=1, then resp_valid with resp_rdata=0x0000000F and resp_err=0.
2. Store byte 0x80 to addr 0x05, then signed load byte 0x05 -> word1=0x00008000, resp_rdata=0xFFFFFF80. Unsigned load of the same byte -> 0x00000080.
3. Store half 0xBEEF to addr 0x02 over word0=0x0000000F -> one RD cycle then one WR cycle with mem_val=0xBEEF000F. Load word 0x00 -> 0xBEEF000F.
4. Load word addr 0x06, load half 0x03, size 11, and (CHECK_RANGE=1) load word 0x80 -> each gives resp_valid with resp_err=1 the cycle after accept. mem_read_flag and mem_write_flag stay 0 throughout.
5. Assert rst during the WR cycle of a byte store -> all outputs 0 and req_ready=1 immediately. The target word is unchanged on readback.
6. req_valid held high for two back-to-back word stores (0x11111111 to 0x08, 0x22222222 to 0x0C) -> req_ready low from accept through RESP. The second accept lands one cycle after the first resp_valid. Both words read back correctly.
